// File: rtl/ts_rate_pkg.sv
// Shared widths, FSM encoding and sum saturation helper for the TS rate collector.
package ts_rate_pkg;

   localparam int unsigned IDX_W     = 12;
   localparam int unsigned RATE_W    = 16;
   localparam int unsigned LEN_W     = IDX_W + 1;
   localparam int unsigned SUM_W     = 32;
   localparam int unsigned SUM_XW    = SUM_W + 1;
   localparam int unsigned RAM_AW    = IDX_W + 1;
   localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

   localparam logic [SUM_W-1:0] SUM_MAX = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      IDLE    = 3'b001,
      CAPTURE = 3'b010,
      SWAP    = 3'b100
   } state_t;

   typedef struct packed {
      logic             ovf;
      logic [LEN_W-1:0] len;
      logic [SUM_W-1:0] sum;
   } rpt_t;

   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0]  acc,
                                                input logic [RATE_W-1:0] beat);
      logic [SUM_XW-1:0] s;
      s = {1'b0, acc} + SUM_XW'(beat);
      return s[SUM_W] ? SUM_MAX : s[SUM_W-1:0];
   endfunction

endpackage

// File: rtl/ts_rate_collector_if.sv
// Rate beat input, host read port and report bus of the TS rate collector.
// loss_cnt exists only when TS_RATE_LOSS_ALARM_EN is defined.
interface ts_rate_collector_if;
   import ts_rate_pkg::*;

   logic [RATE_W-1:0] rate_din;
   logic              rate_din_en;
   logic [IDX_W-1:0]  rd_addr;
   logic              rd_req;
   logic [RATE_W-1:0] rd_data;
   logic              rd_valid;
   logic              rpt_done;
   logic [LEN_W-1:0]  rpt_len;
   logic [SUM_W-1:0]  rpt_sum;
   logic              rpt_ovf;
   logic              snap_valid;
`ifdef TS_RATE_LOSS_ALARM_EN
   logic [LEN_W-1:0]  loss_cnt;
`endif

   modport master (
      output rate_din, rate_din_en, rd_addr, rd_req,
      input  rd_data, rd_valid, rpt_done, rpt_len, rpt_sum, rpt_ovf,
`ifdef TS_RATE_LOSS_ALARM_EN
      input  loss_cnt,
`endif
      input  snap_valid
   );

   modport slave (
      input  rate_din, rate_din_en, rd_addr, rd_req,
      output rd_data, rd_valid, rpt_done, rpt_len, rpt_sum, rpt_ovf,
`ifdef TS_RATE_LOSS_ALARM_EN
      output loss_cnt,
`endif
      output snap_valid
   );

endinterface

// File: rtl/rate_bank_ram.sv
// Simple dual-port 8192x16 RAM, address MSB selects the bank, registered read
// whose output can be forced to zero for reads with no published snapshot.
module rate_bank_ram
   import ts_rate_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [RAM_AW-1:0] wr_addr,
   input  logic [RATE_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              rd_zero,
   input  logic [RAM_AW-1:0] rd_addr,
   output logic [RATE_W-1:0] rd_data
);

   logic [RATE_W-1:0] mem [RAM_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= rd_zero ? '0 : mem[rd_addr];
   end

endmodule

// File: rtl/ts_rate_collector.sv
// Double-buffered per-port TS rate snapshot collector with 2-cycle host reads.
// Optional zero-rate loss counter enabled by TS_RATE_LOSS_ALARM_EN.
module ts_rate_collector
   import ts_rate_pkg::*;
#(
   parameter int unsigned MAX_ENTRIES  = 4096,
   parameter int unsigned ACTIVE_PORTS = 4095
) (
   input  logic               clk,
   input  logic               rst,
   ts_rate_collector_if.slave bus
);

   if (MAX_ENTRIES < 1 || MAX_ENTRIES > (1 << IDX_W) || ACTIVE_PORTS > MAX_ENTRIES) begin : g_cfg_check
      $error("ts_rate_collector: MAX_ENTRIES/ACTIVE_PORTS out of range");
   end

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_ENTRIES);

   state_t            state, state_n;
   logic              start_c, beat_c, swap_c, room_c;
   logic              bank;
   rpt_t              acc, rpt;
   logic              rpt_done, snap_valid;
   logic              wr_en_c;
   logic [RAM_AW-1:0] wr_addr_c;
   logic              rd_req_q, rd_zero_q, rd_valid;
   logic [RAM_AW-1:0] rd_addr_q;
   logic [RATE_W-1:0] rd_data;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      start_c = 1'b0;
      beat_c  = 1'b0;
      swap_c  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.rate_din_en) begin
               start_c = 1'b1;
               state_n = CAPTURE;
            end
         end
         CAPTURE: begin
            if (bus.rate_din_en) beat_c  = 1'b1;
            else                 state_n = SWAP;
         end
         SWAP: begin
            swap_c = 1'b1;
            if (bus.rate_din_en) begin
               start_c = 1'b1;
               state_n = CAPTURE;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // A burst starting in SWAP lands in the bank that is about to become the write bank.
   assign room_c    = (acc.len < MAX_LEN);
   assign wr_en_c   = start_c | (beat_c & room_c);
   assign wr_addr_c = start_c ? {bank ^ swap_c, {IDX_W{1'b0}}} : {bank, acc.len[IDX_W-1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         bank       <= 1'b0;
         snap_valid <= 1'b0;
         rpt_done   <= 1'b0;
         rpt        <= '0;
         acc        <= '0;
      end else begin
         rpt_done <= swap_c;
         if (swap_c) begin
            bank       <= ~bank;
            snap_valid <= 1'b1;
            rpt        <= acc;
         end
         if (start_c) begin
            acc.len <= LEN_W'(1);
            acc.sum <= SUM_W'(bus.rate_din);
            acc.ovf <= 1'b0;
         end else if (beat_c) begin
            if (room_c) begin
               acc.len <= acc.len + LEN_W'(1);
               acc.sum <= sat_add(acc.sum, bus.rate_din);
            end else begin
               acc.ovf <= 1'b1;
            end
         end
      end
   end

`ifdef TS_RATE_LOSS_ALARM_EN
   localparam logic [LEN_W-1:0] ACT_LEN = LEN_W'(ACTIVE_PORTS);

   logic             zero_c;
   logic [LEN_W-1:0] loss_acc, loss_cnt;

   assign zero_c = (bus.rate_din == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         loss_acc <= '0;
         loss_cnt <= '0;
      end else begin
         if (swap_c) loss_cnt <= loss_acc;
         if (start_c)
            loss_acc <= LEN_W'(zero_c && (ACT_LEN != '0));
         else if (beat_c && room_c && zero_c && (acc.len < ACT_LEN))
            loss_acc <= loss_acc + LEN_W'(1);
      end
   end

   assign bus.loss_cnt = loss_cnt;
`endif

   // Bank and snapshot presence are captured with the address, so a read keeps its bank across SWAP.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_req_q  <= 1'b0;
         rd_zero_q <= 1'b1;
         rd_addr_q <= '0;
         rd_valid  <= 1'b0;
      end else begin
         rd_req_q  <= bus.rd_req;
         rd_zero_q <= ~snap_valid;
         rd_addr_q <= {~bank, bus.rd_addr};
         rd_valid  <= rd_req_q;
      end
   end

   rate_bank_ram u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_c),
      .wr_addr (wr_addr_c),
      .wr_data (bus.rate_din),
      .rd_en   (rd_req_q),
      .rd_zero (rd_zero_q),
      .rd_addr (rd_addr_q),
      .rd_data (rd_data)
   );

   assign bus.rd_data    = rd_data;
   assign bus.rd_valid   = rd_valid;
   assign bus.rpt_done   = rpt_done;
   assign bus.rpt_len    = rpt.len;
   assign bus.rpt_sum    = rpt.sum;
   assign bus.rpt_ovf    = rpt.ovf;
   assign bus.snap_valid = snap_valid;

endmodule

// File: doc/ts_rate_collector.md
TS_RATE_COLLECTOR -- requirements
Module: ts_rate_collector

Interface
REQ-001 SHALL have parameter MAX_ENTRIES, default 4096, meaning the maximum rate entries stored per burst (index width 12).
REQ-002 SHALL have parameter ACTIVE_PORTS, default 4095, meaning the number of leading indices checked by the loss counter.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port rate_din, input, 16, the per-port TS packet count beat.
REQ-006 SHALL have port rate_din_en, input, 1, beat valid; one contiguous high run forms one burst.
REQ-007 SHALL have port rd_addr, input, 12, the host read index.
REQ-008 SHALL have port rd_req, input, 1, the host read strobe.
REQ-009 SHALL have port rd_data, output, 16, the snapshot entry.
REQ-010 SHALL have port rd_valid, output, 1, rd_data qualifier.
REQ-011 SHALL have port rpt_done, output, 1, a one-cycle pulse when a new snapshot is published.
REQ-012 SHALL have port rpt_len, output, 13, the entry count of the published snapshot.
REQ-013 SHALL have port rpt_sum, output, 32, the saturating sum of the published entries.
REQ-014 SHALL have port rpt_ovf, output, 1, set when the published burst exceeded MAX_ENTRIES beats.
REQ-015 SHALL have port snap_valid, output, 1, set when at least one snapshot has been published since reset.
REQ-016 SHALL have port loss_cnt, output, 13, the zero-rate entry count (present only under the macro).

Function
REQ-017 SHALL use FSM states IDLE, CAPTURE and SWAP, one-hot encoded.
REQ-018 IDLE SHALL go to CAPTURE when rate_din_en=1; that beat is written at index 0.
REQ-019 CAPTURE SHALL write each beat at index = beat position into the write bank and SHALL go to SWAP on the first cycle with rate_din_en=0.
REQ-020 Beats beyond MAX_ENTRIES SHALL be discarded and SHALL set the pending overflow flag; the index SHALL NOT wrap.
REQ-021 SWAP SHALL last exactly one cycle: toggle the read/write bank, latch rpt_len/rpt_sum/rpt_ovf(/loss_cnt), pulse rpt_done, and set snap_valid.
REQ-022 In SWAP with rate_din_en=1, the FSM SHALL go to CAPTURE and write the beat at index 0 of the new write bank; otherwise it SHALL go to IDLE.
REQ-023 The running sum SHALL saturate at 32'hFFFFFFFF; length, sum and flags SHALL clear at each burst start.
REQ-024 The host read latency SHALL be exactly 2 cycles (address register plus RAM read); rd_valid SHALL equal rd_req delayed by 2.
REQ-025 Host reads SHALL always target the read bank; a read in flight across SWAP SHALL return the bank selected at request time.
REQ-026 When snap_valid=0, rd_data SHALL return 0 while rd_valid still follows rd_req.
REQ-027 Bursts shorter than MAX_ENTRIES SHALL leave stale entries above rpt_len in the bank, and the host SHALL honour rpt_len.

Reset
REQ-028 rst SHALL force: state IDLE, bank pointer 0, snap_valid 0, rpt_done 0, rpt_len 0, rpt_sum 0, rpt_ovf 0, loss_cnt 0, rd_valid 0, rd_data 0.
REQ-029 Reset during CAPTURE SHALL abandon the burst without publishing; RAM contents are not cleared.

Configuration
REQ-030 With macro TS_RATE_LOSS_ALARM_EN defined, the block SHALL count beats with index < ACTIVE_PORTS and value 0, and publish that count on loss_cnt at SWAP.
REQ-031 Without TS_RATE_LOSS_ALARM_EN, loss_cnt and its counter SHALL be absent.

Structure
REQ-032 Package ts_rate_pkg SHALL hold the index and rate widths, the state encoding and the sum saturation constant.
REQ-033 Sub-module rate_bank_ram SHALL implement a simple dual-port RAM of 8192x16 with 1-cycle registered read, where address MSB = bank.

Verification
REQ-034 Burst of 4095 beats with value=index -> one rpt_done pulse, rpt_len=4095, rpt_sum=8382465, rpt_ovf=0; reading index 100 returns 100 after 2 cycles.
REQ-035 Burst of 4100 beats with value 1 -> rpt_len=4096, rpt_ovf=1, rpt_sum=4096.
REQ-036 Two bursts separated by one idle cycle (en low for only the SWAP cycle, then high) -> two rpt_done pulses; the second snapshot is intact with no lost index-0 beat.
REQ-037 Host reads index 5 continuously across a SWAP -> each rd_data matches the bank selected at request time; rd_valid never drops.
REQ-038 Reset asserted mid-burst at beat 2000 -> no rpt_done, snap_valid=0, and reads return 0.
REQ-039 TS_RATE_LOSS_ALARM_EN defined, 4095 beats with 10 zeros at indices <4095 -> loss_cnt=10.
